// File: rtl/msftDvDebug_jtag2AxiApb_pkg.sv
// Shared types for the JTAG-to-APB debug path: command/response formats,
// plus the arbiter state encoding and completion codes.
package msftDvDebug_jtag2AxiApb_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } JTAG_APB_DATA_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } JTAG_APB_RESP_t;

  localparam int APB_CMD_WIDTH  = $bits(JTAG_APB_DATA_t);
  localparam int APB_RESP_WIDTH = $bits(JTAG_APB_RESP_t);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_BUSY,
    ARB_DONE
  } arb_state_e;

  localparam logic [1:0] ARB_STS_OK      = 2'b00;
  localparam logic [1:0] ARB_STS_INC_REJ = 2'b01;
  localparam logic [1:0] ARB_STS_NOP     = 2'b10;

endpackage

// File: rtl/msft_dv_debug_rr_arb2.sv
// Two-input grant selection; the registered pointer names the requester
// favoured on a tie (the one that did not win the most recent grant).
module msft_dv_debug_rr_arb2 #(
  parameter int unsigned RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic ptr_q;

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = (RR_EN != 0) ? ptr_q : 1'b0;
      default: gnt_idx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (en && gnt_valid) begin
      ptr_q <= ~gnt_idx;
    end
  end

endmodule

// File: rtl/msft_dv_debug_apb_arb.sv
// Arbitrates two debug requesters onto a single APB manager, screening nop
// and stolen auto-increment requests before they reach the bus.
module msft_dv_debug_apb_arb
  import msftDvDebug_jtag2AxiApb_pkg::*;
#(
  parameter int unsigned RR_EN     = 1,
  parameter int unsigned OWNER_CHK = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req0_i,
  input  logic [APB_CMD_WIDTH-1:0]  cmd0_i,
  input  logic [1:0]                req1_i,
  input  logic [APB_CMD_WIDTH-1:0]  cmd1_i,
  output logic [1:0]                done_o,
  output logic [1:0]                status_o,
  output logic [APB_RESP_WIDTH-1:0] resp_o,
  output logic [1:0]                apb_req_o,
  input  logic                      apb_ack_i,
  output logic [APB_CMD_WIDTH-1:0]  apb_cmd_o,
  input  logic [APB_RESP_WIDTH-1:0] apb_resp_i,
  input  logic                      sel_jtag_i,
  output logic                      owner_o,
  output logic                      busy_o
);

  arb_state_e                state_q, state_d;
  logic                      owner_q, last_owner_q, first_busy_q;
  logic                      gnt_valid, gnt_idx, is_nop, inc_rej, busy_exit;
  logic [1:0]                req_q, status_q;
  JTAG_APB_DATA_t            cmd_q;
  logic [APB_RESP_WIDTH-1:0] resp_q;

  msft_dv_debug_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .en        (state_q == ARB_IDLE),
    .req       ({|req1_i, |req0_i}),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign is_nop  = !cmd_q.read && !cmd_q.write;
  assign inc_rej = (OWNER_CHK != 0) && (req_q == 2'b10) && (owner_q != last_owner_q);
  // The manager only raises sel_jtag a cycle after accepting, so the first BUSY cycle is blind.
  assign busy_exit = !first_busy_q && !sel_jtag_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    apb_req_o = 2'b00;
    case (state_q)
      ARB_IDLE:  if (gnt_valid) state_d = ARB_ISSUE;
      ARB_ISSUE: begin
        if (is_nop || inc_rej) begin
          state_d = ARB_DONE;
        end else begin
          apb_req_o = req_q;
          if (apb_ack_i) state_d = ARB_BUSY;
        end
      end
      ARB_BUSY:  if (busy_exit) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      first_busy_q <= 1'b0;
      req_q        <= 2'b00;
      cmd_q        <= '0;
      status_q     <= ARB_STS_OK;
      resp_q       <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt_idx;
            req_q   <= gnt_idx ? req1_i : req0_i;
            cmd_q   <= gnt_idx ? cmd1_i : cmd0_i;
          end
        end
        ARB_ISSUE: begin
          if (is_nop) begin
            status_q <= ARB_STS_NOP;
          end else if (inc_rej) begin
            status_q <= ARB_STS_INC_REJ;
          end else if (apb_ack_i) begin
            status_q     <= ARB_STS_OK;
            last_owner_q <= owner_q;
            first_busy_q <= 1'b1;
          end
        end
        ARB_BUSY: begin
          first_busy_q <= 1'b0;
          if (busy_exit) resp_q <= apb_resp_i;
        end
        default: ;
      endcase
    end
  end

  assign done_o    = (state_q == ARB_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign status_o  = (state_q == ARB_DONE) ? status_q : 2'b00;
  assign resp_o    = resp_q;
  assign apb_cmd_o = cmd_q;
  assign owner_o   = owner_q;
  assign busy_o    = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_msft_dv_debug_apb_arb.sv
// Bench for the debug APB arbiter: a simple APB manager model plus a
// transaction-level reference for grant order, owner tracking and completion codes.
module tb_msft_dv_debug_apb_arb;
  import msftDvDebug_jtag2AxiApb_pkg::*;

  localparam int RR_EN     = 1;
  localparam int OWNER_CHK = 1;
  localparam int TIMEOUT   = 80;

  logic clk, rst;
  logic [1:0] req0, req1, done, status, apb_req;
  logic [APB_CMD_WIDTH-1:0] cmd0, cmd1, apb_cmd;
  logic [APB_RESP_WIDTH-1:0] resp, apb_resp;
  logic apb_ack, sel_jtag, owner, busy;

  int vectors, miscompares;
  int busy_n, ack_delay, mgr_cnt, ack_wait;
  logic [APB_RESP_WIDTH-1:0] next_resp, mgr_resp;
  logic m_pref, m_last_owner;
  logic [APB_RESP_WIDTH-1:0] m_resp;

  msft_dv_debug_apb_arb #(.RR_EN(RR_EN), .OWNER_CHK(OWNER_CHK)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .cmd0_i(cmd0), .req1_i(req1), .cmd1_i(cmd1),
    .done_o(done), .status_o(status), .resp_o(resp),
    .apb_req_o(apb_req), .apb_ack_i(apb_ack), .apb_cmd_o(apb_cmd),
    .apb_resp_i(apb_resp), .sel_jtag_i(sel_jtag),
    .owner_o(owner), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Manager model: accepts after ack_delay waiting cycles, then stays busy for busy_n cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mgr_cnt  <= 0;
      ack_wait <= 0;
      mgr_resp <= '0;
    end else if (mgr_cnt != 0) begin
      mgr_cnt <= mgr_cnt - 1;
    end else if (apb_ack) begin
      mgr_cnt  <= busy_n;
      ack_wait <= 0;
      mgr_resp <= next_resp;
    end else if (apb_req != 2'b00) begin
      ack_wait <= ack_wait + 1;
    end
  end
  assign apb_ack  = (mgr_cnt == 0) && (apb_req != 2'b00) && (ack_wait >= ack_delay);
  assign sel_jtag = (mgr_cnt != 0);
  assign apb_resp = mgr_resp;

  function automatic logic [APB_CMD_WIDTH-1:0] mk_cmd(input logic rd, input logic wr,
                                                      input logic [31:0] addr, input logic [31:0] wdata);
    JTAG_APB_DATA_t c;
    c.read = rd; c.write = wr; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  // Reference: the tie goes to whoever did not win the previous grant.
  task automatic model_grant(input logic [1:0] elig, output logic w);
    if (elig == 2'b11) w = (RR_EN != 0) ? m_pref : 1'b0;
    else               w = elig[1];
    m_pref = ~w;
  endtask

  task automatic model_complete(input logic w, input logic [1:0] rc,
                                input logic [APB_CMD_WIDTH-1:0] c, output logic [1:0] st);
    JTAG_APB_DATA_t cs;
    cs = c;
    if (!cs.read && !cs.write) begin
      st = ARB_STS_NOP;
    end else if (OWNER_CHK != 0 && rc == 2'b10 && w != m_last_owner) begin
      st = ARB_STS_INC_REJ;
    end else begin
      st = ARB_STS_OK;
      m_last_owner = w;
      m_resp = next_resp;
    end
  endtask

  task automatic wait_done(output logic [1:0] d, output logic [1:0] s,
                           output logic [APB_RESP_WIDTH-1:0] r, output int lat,
                           output int reqc, output int selc, output int unstable);
    logic [1:0] fr;
    logic [APB_CMD_WIDTH-1:0] fc;
    bit have;
    d = '0; s = '0; r = '0; lat = -1; reqc = 0; selc = 0; unstable = 0;
    have = 0; fr = '0; fc = '0;
    for (int i = 1; i <= TIMEOUT && lat < 0; i++) begin
      @(negedge clk);
      if (apb_req != 2'b00) begin
        if (!have) begin
          fr = apb_req; fc = apb_cmd; have = 1;
        end else if (apb_req !== fr || apb_cmd !== fc) begin
          unstable++;
        end
        reqc++;
      end
      if (sel_jtag) selc++;
      if (done != 2'b00) begin
        d = done; s = status; r = resp; lat = i;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++; if (done !== 2'b00) begin miscompares++; $display("[TB] FAIL reset.done got %b want 00", done); end
    vectors++; if (status !== 2'b00) begin miscompares++; $display("[TB] FAIL reset.status got %b want 00", status); end
    vectors++; if (apb_req !== 2'b00) begin miscompares++; $display("[TB] FAIL reset.apb_req got %b want 00", apb_req); end
    vectors++; if (owner !== 1'b0) begin miscompares++; $display("[TB] FAIL reset.owner got %b want 0", owner); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset.busy got %b want 0", busy); end
    vectors++; if (apb_cmd !== '0) begin miscompares++; $display("[TB] FAIL reset.apb_cmd got %h want 0", apb_cmd); end
    vectors++; if (resp !== '0) begin miscompares++; $display("[TB] FAIL reset.resp got %h want 0", resp); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    logic w; logic [1:0] st, d, s; logic [APB_RESP_WIDTH-1:0] r; int lat, rc, sc, un;
    busy_n = 3; ack_delay = 0; next_resp = {1'b0, 32'h0000_1234};
    req0 = 2'b01; cmd0 = mk_cmd(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    model_grant(2'b01, w); model_complete(w, req0, cmd0, st);
    wait_done(d, s, r, lat, rc, sc, un);
    vectors++; if (d !== 2'b01) begin miscompares++; $display("[TB] FAIL single_read.done got %b want 01", d); end
    vectors++; if (s !== st) begin miscompares++; $display("[TB] FAIL single_read.status got %b want %b", s, st); end
    vectors++; if (r[31:0] !== 32'h1234) begin miscompares++; $display("[TB] FAIL single_read.data got %h want 1234", r[31:0]); end
    vectors++; if (lat != 6) begin miscompares++; $display("[TB] FAIL single_read.latency got %0d want 6", lat); end
    vectors++; if (sc != 3) begin miscompares++; $display("[TB] FAIL single_read.sel_cycles got %0d want 3", sc); end
    req0 = 2'b00;
    @(negedge clk);
    vectors++; if (done !== 2'b00) begin miscompares++; $display("[TB] FAIL single_read.pulse got %b want 00", done); end
  endtask

  task automatic test_nop;
    logic w; logic [1:0] st, d, s; logic [APB_RESP_WIDTH-1:0] r; int lat, rc, sc, un;
    req0 = 2'b01; cmd0 = mk_cmd(1'b0, 1'b0, 32'h0000_2000, 32'hdead_beef);
    model_grant(2'b01, w); model_complete(w, req0, cmd0, st);
    wait_done(d, s, r, lat, rc, sc, un);
    vectors++; if (d !== 2'b01) begin miscompares++; $display("[TB] FAIL nop.done got %b want 01", d); end
    vectors++; if (s !== st) begin miscompares++; $display("[TB] FAIL nop.status got %b want %b", s, st); end
    vectors++; if (lat != 2) begin miscompares++; $display("[TB] FAIL nop.latency got %0d want 2", lat); end
    vectors++; if (rc != 0) begin miscompares++; $display("[TB] FAIL nop.apb_req_cycles got %0d want 0", rc); end
    vectors++; if (r !== m_resp) begin miscompares++; $display("[TB] FAIL nop.resp got %h want %h", r, m_resp); end
    req0 = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_stolen_inc;
    logic w; logic [1:0] st, d, s; logic [APB_RESP_WIDTH-1:0] r; int lat, rc, sc, un;
    busy_n = 2; next_resp = {1'b0, 32'h0bad_f00d};
    req1 = 2'b01; cmd1 = mk_cmd(1'b0, 1'b1, 32'h0000_3000, 32'h1111_2222);
    model_grant(2'b10, w); model_complete(w, req1, cmd1, st);
    wait_done(d, s, r, lat, rc, sc, un);
    vectors++; if (d !== 2'b10) begin miscompares++; $display("[TB] FAIL stolen.write_done got %b want 10", d); end
    vectors++; if (s !== st) begin miscompares++; $display("[TB] FAIL stolen.write_status got %b want %b", s, st); end
    req1 = 2'b00;
    @(negedge clk);
    req0 = 2'b10; cmd0 = mk_cmd(1'b1, 1'b0, 32'h0000_3004, 32'h0);
    model_grant(2'b01, w); model_complete(w, req0, cmd0, st);
    wait_done(d, s, r, lat, rc, sc, un);
    vectors++; if (d !== 2'b01) begin miscompares++; $display("[TB] FAIL stolen.inc_done got %b want 01", d); end
    vectors++; if (s !== st) begin miscompares++; $display("[TB] FAIL stolen.inc_status got %b want %b", s, st); end
    vectors++; if (rc != 0) begin miscompares++; $display("[TB] FAIL stolen.apb_req_cycles got %0d want 0", rc); end
    vectors++; if (sc != 0) begin miscompares++; $display("[TB] FAIL stolen.sel_cycles got %0d want 0", sc); end
    vectors++; if (r !== m_resp) begin miscompares++; $display("[TB] FAIL stolen.resp got %h want %h", r, m_resp); end
    req0 = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_slow_ack;
    logic w; logic [1:0] st, d, s; logic [APB_RESP_WIDTH-1:0] r; int lat, rc, sc, un;
    busy_n = 2; ack_delay = 5; next_resp = {1'b1, 32'h5a5a_0001};
    req1 = 2'b01; cmd1 = mk_cmd(1'b1, 1'b0, 32'h0000_4000, 32'h0);
    model_grant(2'b10, w); model_complete(w, req1, cmd1, st);
    wait_done(d, s, r, lat, rc, sc, un);
    vectors++; if (rc != 6) begin miscompares++; $display("[TB] FAIL slow_ack.apb_req_cycles got %0d want 6", rc); end
    vectors++; if (un != 0) begin miscompares++; $display("[TB] FAIL slow_ack.unstable_cycles got %0d want 0", un); end
    vectors++; if (lat != 3 + 2 + 5) begin miscompares++; $display("[TB] FAIL slow_ack.latency got %0d want 10", lat); end
    vectors++; if (s !== st) begin miscompares++; $display("[TB] FAIL slow_ack.status got %b want %b", s, st); end
    vectors++; if (r !== m_resp) begin miscompares++; $display("[TB] FAIL slow_ack.resp got %h want %h", r, m_resp); end
    req1 = 2'b00; ack_delay = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic w; logic [1:0] st, d, s; logic [APB_RESP_WIDTH-1:0] r; int lat, rc, sc, un;
    busy_n = 1; ack_delay = 0;
    req0 = 2'b01; cmd0 = mk_cmd(1'b1, 1'b0, 32'h0000_5000, 32'h0);
    req1 = 2'b01; cmd1 = mk_cmd(1'b1, 1'b0, 32'h0000_6000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      next_resp = {1'b0, $urandom};
      model_grant(2'b11, w); model_complete(w, 2'b01, w ? cmd1 : cmd0, st);
      wait_done(d, s, r, lat, rc, sc, un);
      vectors++; if (d !== (w ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL b2b[%0d].done got %b want %b", k, d, w ? 2'b10 : 2'b01); end
      vectors++; if (lat != ((k == 0) ? 4 : 5)) begin miscompares++; $display("[TB] FAIL b2b[%0d].latency got %0d want %0d", k, lat, (k == 0) ? 4 : 5); end
      vectors++; if (r !== m_resp) begin miscompares++; $display("[TB] FAIL b2b[%0d].resp got %h want %h", k, r, m_resp); end
    end
    req0 = 2'b00; req1 = 2'b00;
    @(negedge clk);
    vectors++; if (done !== 2'b00) begin miscompares++; $display("[TB] FAIL b2b.pulse got %b want 00", done); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 25; it++) begin
      logic w; logic [1:0] st, d, s, mask, rw; logic [APB_RESP_WIDTH-1:0] r;
      int lat, rc, sc, un, exp_lat, exp_rc; bit first, issued;
      logic [1:0] rq [2];
      logic [APB_CMD_WIDTH-1:0] cm [2];
      mask = 2'($urandom_range(3, 1));
      for (int k = 0; k < 2; k++) begin
        rq[k] = 2'($urandom_range(3, 1));
        rw = 2'($urandom_range(3, 1));
        if ($urandom_range(4, 0) == 0) rw = 2'b00;
        cm[k] = mk_cmd(rw[1], rw[0], $urandom, $urandom);
      end
      req0 = mask[0] ? rq[0] : 2'b00; cmd0 = cm[0];
      req1 = mask[1] ? rq[1] : 2'b00; cmd1 = cm[1];
      first = 1;
      while (mask != 2'b00) begin
        busy_n = int'($urandom_range(4, 1));
        ack_delay = int'($urandom_range(2, 0));
        next_resp = {1'($urandom_range(1, 0)), $urandom};
        model_grant(mask, w); model_complete(w, rq[w], cm[w], st);
        issued = (st == ARB_STS_OK);
        exp_lat = (first ? 0 : 1) + (issued ? 3 + busy_n + ack_delay : 2);
        exp_rc = issued ? ack_delay + 1 : 0;
        wait_done(d, s, r, lat, rc, sc, un);
        vectors++; if (d !== (w ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL rand[%0d].done got %b want %b", it, d, w ? 2'b10 : 2'b01); end
        vectors++; if (s !== st) begin miscompares++; $display("[TB] FAIL rand[%0d].status got %b want %b", it, s, st); end
        vectors++; if (r !== m_resp) begin miscompares++; $display("[TB] FAIL rand[%0d].resp got %h want %h", it, r, m_resp); end
        vectors++; if (lat != exp_lat) begin miscompares++; $display("[TB] FAIL rand[%0d].latency got %0d want %0d", it, lat, exp_lat); end
        vectors++; if (rc != exp_rc) begin miscompares++; $display("[TB] FAIL rand[%0d].apb_req_cycles got %0d want %0d", it, rc, exp_rc); end
        vectors++; if (owner !== w) begin miscompares++; $display("[TB] FAIL rand[%0d].owner got %b want %b", it, owner, w); end
        mask[w] = 1'b0;
        if (w) req1 = 2'b00; else req0 = 2'b00;
        first = 0;
      end
      @(negedge clk);
      vectors++; if (done !== 2'b00) begin miscompares++; $display("[TB] FAIL rand[%0d].pulse got %b want 00", it, done); end
    end
  endtask

  task automatic test_reset_busy;
    logic w; logic [1:0] st, d, s; logic [APB_RESP_WIDTH-1:0] r; int lat, rc, sc, un, dcnt;
    busy_n = 6; ack_delay = 0; next_resp = {1'b0, 32'h7777_0000};
    req1 = 2'b01; cmd1 = mk_cmd(1'b1, 1'b0, 32'h0000_7000, 32'h0);
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b1 || sel_jtag !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_busy.in_busy got busy=%b sel=%b want 1 1", busy, sel_jtag); end
    rst = 1'b1;
    #1;
    vectors++; if (done !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_busy.done got %b want 00", done); end
    vectors++; if (status !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_busy.status got %b want 00", status); end
    vectors++; if (apb_req !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_busy.apb_req got %b want 00", apb_req); end
    vectors++; if (owner !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy.owner got %b want 0", owner); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy.busy got %b want 0", busy); end
    vectors++; if (apb_cmd !== '0) begin miscompares++; $display("[TB] FAIL rst_busy.apb_cmd got %h want 0", apb_cmd); end
    vectors++; if (resp !== '0) begin miscompares++; $display("[TB] FAIL rst_busy.resp got %h want 0", resp); end
    req1 = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    m_pref = 1'b0; m_last_owner = 1'b0; m_resp = '0;
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done != 2'b00) dcnt++;
    end
    vectors++; if (dcnt != 0) begin miscompares++; $display("[TB] FAIL rst_busy.stray_done got %0d want 0", dcnt); end
    // After reset the last owner is requester 0, so its increment is accepted.
    busy_n = 2; next_resp = {1'b0, 32'h0000_abcd};
    req0 = 2'b10; cmd0 = mk_cmd(1'b1, 1'b0, 32'h0000_7004, 32'h0);
    model_grant(2'b01, w); model_complete(w, req0, cmd0, st);
    wait_done(d, s, r, lat, rc, sc, un);
    vectors++; if (d !== 2'b01) begin miscompares++; $display("[TB] FAIL rst_busy.after_done got %b want 01", d); end
    vectors++; if (s !== st) begin miscompares++; $display("[TB] FAIL rst_busy.after_status got %b want %b", s, st); end
    vectors++; if (r !== m_resp) begin miscompares++; $display("[TB] FAIL rst_busy.after_resp got %h want %h", r, m_resp); end
    vectors++; if (lat != 5) begin miscompares++; $display("[TB] FAIL rst_busy.after_latency got %0d want 5", lat); end
    req0 = 2'b00;
    @(negedge clk);
    req1 = 2'b10; cmd1 = mk_cmd(1'b0, 1'b1, 32'h0000_7008, 32'h55);
    model_grant(2'b10, w); model_complete(w, req1, cmd1, st);
    wait_done(d, s, r, lat, rc, sc, un);
    vectors++; if (s !== st) begin miscompares++; $display("[TB] FAIL rst_busy.inc1_status got %b want %b", s, st); end
    vectors++; if (rc != 0) begin miscompares++; $display("[TB] FAIL rst_busy.inc1_apb_req_cycles got %0d want 0", rc); end
    req1 = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; req0 = 2'b00; req1 = 2'b00; cmd0 = '0; cmd1 = '0;
    busy_n = 1; ack_delay = 0; next_resp = '0;
    m_pref = 1'b0; m_last_owner = 1'b0; m_resp = '0;
    test_reset;
    test_single_read;
    test_nop;
    test_stolen_inc;
    test_slow_ack;
    test_back_to_back;
    test_random;
    test_reset_busy;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msft_dv_debug_apb_arb.md
MSFT_DV_DEBUG_APB_ARB -- requirements
Module: msft_dv_debug_apb_arb

Interface
REQ-001 Parameters SHALL be, one per line:
- RR_EN, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 highest.
- OWNER_CHK, default 1: 1 = reject an auto-increment request from a requester that did not own the previous issued transaction.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  asynchronous, active-high reset.
- req0_i  in  2  requester 0 request; [0] = new address, [1] = auto-increment.
- cmd0_i  in  APB_CMD_WIDTH  requester 0 command (JTAG_APB_DATA_t).
- req1_i  in  2  requester 1 request; same encoding as req0_i.
- cmd1_i  in  APB_CMD_WIDTH  requester 1 command (JTAG_APB_DATA_t).
- done_o  out  2  one-cycle completion pulse, one bit per requester.
- status_o  out  2  completion code, valid with done_o: 00 ok, 01 increment rejected, 10 nop.
- resp_o  out  APB_RESP_WIDTH  registered APB response (JTAG_APB_RESP_t), valid with done_o.
- apb_req_o  out  2  request to the APB manager.
- apb_ack_i  in  1  manager accept; combinational from apb_req_o while the manager is idle.
- apb_cmd_o  out  APB_CMD_WIDTH  command to the manager.
- apb_resp_i  in  APB_RESP_WIDTH  manager response.
- sel_jtag_i  in  1  manager busy; high while the manager is not idle.
- owner_o  out  1  requester currently granted.
- busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-003 States SHALL be IDLE, ISSUE, BUSY, DONE.
REQ-004 Eligibility: a requester SHALL be eligible when its req is nonzero.
REQ-005 IDLE arbitration:
- If any requester is eligible, register the grant into owner_o, latch that requester's req and cmd, and go to ISSUE.
- RR_EN=1: on a tie, grant the requester that did not win the last grant.
- RR_EN=0: on a tie, grant requester 0.
REQ-006 Nop check: in ISSUE, a latched cmd with read=0 and write=0 SHALL NOT be issued; go to DONE with status 10.
REQ-007 Owner check: in ISSUE, when OWNER_CHK=1, req[0]=0, req[1]=1 and owner differs from last_owner, the request SHALL NOT be issued; go to DONE with status 01.
REQ-008 Issue:
- Otherwise apb_req_o SHALL equal the latched req and apb_cmd_o the latched cmd.
- Both SHALL be held until apb_ack_i is sampled high.
- On that edge, load last_owner with owner and go to BUSY.
REQ-009 BUSY: apb_req_o SHALL be 0.
- The first BUSY cycle SHALL ignore sel_jtag_i.
- On any later cycle with sel_jtag_i=0, capture apb_resp_i into resp_o and go to DONE with status 00.
REQ-010 DONE:
- done_o[owner] SHALL be 1 for exactly one cycle, with status_o and resp_o valid that cycle.
- Next state SHALL be IDLE.
- resp_o SHALL hold its value until the next capture.
REQ-011 Requester handshake:
- Requesters hold req/cmd until their done pulse.
- A requester that drops req before done is still completed.
- Its done pulse is still generated.
REQ-012 Minimum latency SHALL be IDLE grant at T0, ISSUE plus ack at T1, BUSY at T2, DONE at T2+N+1, where N is the number of manager busy cycles.
REQ-013 A requester whose req remains asserted in the IDLE cycle after its own DONE SHALL be treated as a new request.

Reset
REQ-014 While rst_i=1, asynchronously:
- state SHALL be IDLE.
- done_o, status_o, apb_req_o, owner_o and busy_o SHALL be 0.
- apb_cmd_o and resp_o SHALL be all-zero.
- last_owner SHALL be 0, and the round-robin pointer SHALL favour requester 0.
REQ-015 Reset asserted mid-transaction SHALL abandon it with no done pulse.
- The first request after reset with req=10 SHALL be rejected only if its owner differs from 0.

Structure
REQ-016 The following SHALL live in msftDvDebug_jtag2AxiApb_pkg:
- APB_CMD_WIDTH, APB_RESP_WIDTH, JTAG_APB_DATA_t and JTAG_APB_RESP_t (existing).
- New: the arbiter state enum and status code constants.
REQ-017 Grant computation SHALL be one sub-module, msft_dv_debug_rr_arb2: a 2-input round-robin/fixed arbiter with a registered pointer; everything else lives in the top.

Verification
REQ-018 Single read: req0=01, cmd read addr 0x1000, manager busy 3 cycles returning data 0x1234 -> done_o=01 at T2+4, status 00, resp_o.data=0x1234.
REQ-019 Simultaneous requests: req0=01 and req1=01 held, RR_EN=1, back-to-back -> grant order 0,1,0,1; each done pulse is one cycle.
REQ-020 Stolen increment: requester 1 write then requester 0 req=10 -> status 01, no apb_req_o assertion, manager sel_jtag_i stays 0.
REQ-021 Nop: cmd0 read=0 write=0, req0=01 -> done_o=01 with status 10 two cycles after grant; apb_req_o never asserted.
REQ-022 Slow ack: apb_ack_i held low 5 cycles -> apb_req_o and apb_cmd_o stable for all 5 cycles; BUSY entered on the ack edge.
REQ-023 Reset in BUSY: rst_i pulsed during BUSY -> all outputs 0 the same cycle and no done_o; the next request proceeds normally.
